// File: rtl/cart_pkg.sv
// cart_pkg: cartridge header offsets, loader FSM states and mask decoders
package cart_pkg;
  localparam int HDR_LOGO   = 'h104;
  localparam int HDR_SUM_LO = 'h134;
  localparam int HDR_CGB    = 'h143;
  localparam int HDR_SGB    = 'h146;
  localparam int HDR_TYPE   = 'h147;
  localparam int HDR_ROMSZ  = 'h148;
  localparam int HDR_RAMSZ  = 'h149;
  localparam int HDR_SGBID  = 'h14B;
  localparam int HDR_SUM_HI = 'h14C;
  localparam int HDR_CHK    = 'h14D;
  localparam int LOGO_LEN   = 16;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} ld_state_t;
  function automatic logic [31:0] rom_mask_f(input logic [7:0] s, input int w);
    logic [31:0] raw;
    raw = (s > 8'd8) ? 32'h7f : (32'd1 << (s + 8'd1)) - 32'd1;
    return raw & ((32'd1 << w) - 32'd1);
  endfunction
  function automatic logic [3:0] ram_mask_f(input logic [7:0] s);
    return (s < 8'd3) ? 4'h0 : (s == 8'd3) ? 4'h3 : 4'hf;
  endfunction
endpackage

// File: rtl/cart_hdr_checksum.sv
// cart_hdr_checksum: byte-serial header checksum over all byte lanes of a beat
module cart_hdr_checksum
  import cart_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 25
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          clr,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  output logic          done,
  output logic          ok
);
  localparam int B = DW / 8;
  logic [7:0] acc, acc_n, cmp;
  logic [AW-1:0] ba;
  logic hit;
  // lanes walk in address order so the checksum byte sees any subtraction earlier in the same beat
  always_comb begin
    acc_n = acc;
    hit = 1'b0;
    cmp = 8'h00;
    ba = '0;
    for (int i = 0; i < B; i++) begin
      ba = addr + AW'(i);
      if (wr && ba >= AW'(HDR_SUM_LO) && ba <= AW'(HDR_SUM_HI)) acc_n = acc_n - data[8*i +: 8] - 8'd1;
      if (wr && ba == AW'(HDR_CHK)) begin
        hit = 1'b1;
        cmp = data[8*i +: 8];
      end
    end
  end
  // accumulator and verdict registers, cleared at the start of every download
  always_ff @(posedge clk_sys)
    if (reset || clr) begin
      acc <= 8'h00;
      done <= 1'b0;
      ok <= 1'b0;
    end else if (wr) begin
      acc <= acc_n;
      if (hit) begin
        done <= 1'b1;
        ok <= cmp == acc_n;
      end
    end
endmodule

// File: rtl/cart_header_loader.sv
// cart_header_loader: snoops the ROM download, latches header fields and paces SDRAM writes
module cart_header_loader
  import cart_pkg::*;
#(
  parameter int DW         = 16,
  parameter int AW         = 25,
  parameter int PROBES     = 4,
  parameter int PROBE_SH   = 18,
  parameter int ROM_MASK_W = 9
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  ce_cpu,
  input  logic                  ce_cpu2x,
  input  logic                  speed,
  input  logic                  cart_download,
  input  logic                  ioctl_wr,
  input  logic [AW-1:0]         ioctl_addr,
  input  logic [DW-1:0]         ioctl_dout,
  output logic                  ioctl_wait,
  output logic                  dn_write,
  output logic                  cart_ready,
  output logic [7:0]            mbc_type,
  output logic [7:0]            rom_size,
  output logic [7:0]            ram_size,
  output logic                  is_gbc,
  output logic                  is_sgb,
  output logic [ROM_MASK_W-1:0] rom_mask,
  output logic [3:0]            ram_mask,
  output logic [PROBES-1:0]     probe_match,
  output logic                  multicart,
  output logic                  hdr_done,
  output logic                  hdr_chk_ok
);
  localparam int B = DW / 8;
  ld_state_t state, state_n;
  logic dl_q, rise, start, take, tick;
  logic [7:0] cgb, sgb, sgb_id;
  logic [7:0] logo [PROBES+1][LOGO_LEN];
  logic [LOGO_LEN-1:0] seen [PROBES+1];
  assign rise = cart_download & ~dl_q;
  assign start = rise & (state != LOAD);
  assign take = ioctl_wr & (state == LOAD);
  assign tick = speed ? ce_cpu2x : ce_cpu;
  assign is_gbc = (cgb == 8'h80) || (cgb == 8'hc0);
  assign is_sgb = (sgb == 8'h03) && (sgb_id == 8'h33);
  assign multicart = probe_match[0];
  // download history resets high so a download still active across reset does not count as a new one
  always_ff @(posedge clk_sys)
    if (reset) begin
      state <= IDLE;
      dl_q <= 1'b1;
    end else begin
      state <= state_n;
      dl_q <= cart_download;
    end
  // LOAD lasts while cart_download is high; only a fresh rising edge starts another parse
  always_comb begin
    state_n = (state == LOAD) ? (cart_download ? LOAD : DONE) : (rise ? LOAD : state);
  end
  // header bytes and logo banks are captured by exact byte address, lane by lane
  always_ff @(posedge clk_sys)
    if (reset || start) begin
      mbc_type <= 8'h00;
      rom_size <= 8'h00;
      ram_size <= 8'h00;
      cgb <= 8'h00;
      sgb <= 8'h00;
      sgb_id <= 8'h00;
      rom_mask <= '0;
      ram_mask <= 4'h0;
      for (int b = 0; b <= PROBES; b++) seen[b] <= '0;
    end else if (take)
      for (int i = 0; i < B; i++) begin
        if (ioctl_addr + AW'(i) == AW'(HDR_CGB)) cgb <= ioctl_dout[8*i +: 8];
        if (ioctl_addr + AW'(i) == AW'(HDR_SGB)) sgb <= ioctl_dout[8*i +: 8];
        if (ioctl_addr + AW'(i) == AW'(HDR_SGBID)) sgb_id <= ioctl_dout[8*i +: 8];
        if (ioctl_addr + AW'(i) == AW'(HDR_TYPE)) mbc_type <= ioctl_dout[8*i +: 8];
        if (ioctl_addr + AW'(i) == AW'(HDR_ROMSZ)) begin
          rom_size <= ioctl_dout[8*i +: 8];
          rom_mask <= ROM_MASK_W'(rom_mask_f(ioctl_dout[8*i +: 8], ROM_MASK_W));
        end
        if (ioctl_addr + AW'(i) == AW'(HDR_RAMSZ)) begin
          ram_size <= ioctl_dout[8*i +: 8];
          ram_mask <= ram_mask_f(ioctl_dout[8*i +: 8]);
        end
        for (int b = 0; b <= PROBES; b++)
          for (int j = 0; j < LOGO_LEN; j++)
            if (ioctl_addr + AW'(i) == AW'((b << PROBE_SH) + HDR_LOGO + j)) begin
              logo[b][j] <= ioctl_dout[8*i +: 8];
              seen[b][j] <= 1'b1;
            end
      end
  // a probe matches only when it and bank 0 are fully written and every logo byte agrees
  always_comb begin
    probe_match = '0;
    for (int k = 0; k < PROBES; k++) begin
      probe_match[k] = (&seen[k+1]) & (&seen[0]);
      for (int j = 0; j < LOGO_LEN; j++) probe_match[k] = probe_match[k] & (logo[k+1][j] == logo[0][j]);
    end
  end
  // ioctl_wr raises the stall; ticks turn it into a one-tick write pulse and then release it
  always_ff @(posedge clk_sys)
    if (reset) begin
      ioctl_wait <= 1'b0;
      dn_write <= 1'b0;
      cart_ready <= 1'b0;
    end else begin
      if (ioctl_wr) ioctl_wait <= 1'b1;
      if (tick) begin
        dn_write <= ioctl_wait & ~dn_write;
        if (dn_write) begin
          ioctl_wait <= 1'b0;
          cart_ready <= 1'b1;
        end
      end
    end
  cart_hdr_checksum #(.DW(DW), .AW(AW)) u_chk (
    .clk_sys(clk_sys),
    .reset(reset),
    .clr(start),
    .wr(take),
    .addr(ioctl_addr),
    .data(ioctl_dout),
    .done(hdr_done),
    .ok(hdr_chk_ok)
  );
endmodule
